// File: rtl/sdr_arb.sv
// Two-port round-robin arbiter feeding one SDR controller burst interface.
// Define SDR_ARB_WDOG_EN to add a data-phase watchdog that aborts stalled bursts.
module sdr_arb #(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [15:0] m0_wdata,
   input  logic        m0_wvld,
   output logic        m0_wready,
   output logic [15:0] m0_rdata,
   output logic        m0_rvld,
   output logic        m0_ack,
   output logic        m0_done,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [15:0] m1_wdata,
   input  logic        m1_wvld,
   output logic        m1_wready,
   output logic [15:0] m1_rdata,
   output logic        m1_rvld,
   output logic        m1_ack,
   output logic        m1_done,
   output logic        sdr_wr_req,
   output logic [31:0] sdr_waddr,
   output logic [15:0] sdr_wdata_in,
   output logic        sdr_wr_vld,
   input  logic        sdr_wr_ready,
   output logic        sdr_rd_req,
   output logic [31:0] sdr_raddr,
   input  logic [15:0] sdr_rdata_out,
   input  logic        sdr_rd_vld,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WR_DATA, RD_DATA} state_t;

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   state_t      state, state_nxt;
   logic        gnt, last_gnt, we_r, done_r;
   logic [31:0] addr_r;
   logic [7:0]  beat_cnt;
   logic        any_req, win, wr_phase, rd_phase, beat, last_beat, abort;

   assign any_req   = m0_req | m1_req;
   // On a tie the port that was not served last wins.
   assign win       = (m0_req & m1_req) ? ~last_gnt : m1_req;
   assign wr_phase  = (state == WR_DATA);
   assign rd_phase  = (state == RD_DATA);
   assign beat      = (wr_phase & (gnt ? m1_wvld : m0_wvld) & sdr_wr_ready) |
                      (rd_phase & sdr_rd_vld);
   assign last_beat = beat & (beat_cnt == LAST_BEAT);

`ifdef SDR_ARB_WDOG_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

   logic [15:0] wd_cnt;
   logic        err_r;

   // wd_cnt is zero in the first data cycle, so the abort lands TIMEOUT cycles after entry.
   assign abort = (wr_phase | rd_phase) & ~beat & (wd_cnt == WD_LIMIT);
   assign err   = err_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         err_r  <= 1'b0;
      end else begin
         if ((wr_phase | rd_phase) & ~beat) wd_cnt <= wd_cnt + 16'd1;
         else                               wd_cnt <= '0;
         if (abort) err_r <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign abort          = 1'b0;
   assign err            = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:             if (any_req) state_nxt = ISSUE;
         ISSUE:            state_nxt = we_r ? WR_DATA : RD_DATA;
         WR_DATA, RD_DATA: if (last_beat | abort) state_nxt = IDLE;
         default:          state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
         we_r     <= 1'b0;
         addr_r   <= '0;
         beat_cnt <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= last_beat | abort;
         if ((state == IDLE) && any_req) begin
            gnt    <= win;
            we_r   <= win ? m1_we : m0_we;
            addr_r <= win ? m1_addr : m0_addr;
         end
         if (last_beat | abort) begin
            beat_cnt <= '0;
            last_gnt <= gnt;
         end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
      end
   end

   assign m0_ack       = (state == ISSUE) & ~gnt;
   assign m1_ack       = (state == ISSUE) & gnt;
   assign m0_done      = done_r & ~gnt;
   assign m1_done      = done_r & gnt;
   assign sdr_wr_req   = (state == ISSUE) & we_r;
   assign sdr_rd_req   = (state == ISSUE) & ~we_r;
   assign sdr_waddr    = addr_r;
   assign sdr_raddr    = addr_r;
   assign sdr_wr_vld   = wr_phase & (gnt ? m1_wvld : m0_wvld);
   assign sdr_wdata_in = wr_phase ? (gnt ? m1_wdata : m0_wdata) : '0;
   assign m0_wready    = wr_phase & ~gnt & sdr_wr_ready;
   assign m1_wready    = wr_phase & gnt & sdr_wr_ready;
   assign m0_rdata     = sdr_rdata_out;
   assign m1_rdata     = sdr_rdata_out;
   assign m0_rvld      = rd_phase & ~gnt & sdr_rd_vld;
   assign m1_rvld      = rd_phase & gnt & sdr_rd_vld;

endmodule

// File: tb/tb_sdr_arb.sv
// Bench for sdr_arb: vector table for idle behaviour, directed bursts, and a
// randomized burst mix checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_sdr_arb;
   localparam int unsigned BL = 8;
   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req, we, wvld;
   logic [31:0] addr [2];
   logic [15:0] wdata [2];
   wire  [1:0]  wready, rvld, ack, done;
   wire  [15:0] m0_rdata, m1_rdata;
   wire         sdr_wr_req, sdr_rd_req, sdr_wr_vld, err;
   wire  [31:0] sdr_waddr, sdr_raddr;
   wire  [15:0] sdr_wdata_in;
   logic        sdr_wr_ready, sdr_rd_vld;
   logic [15:0] sdr_rdata_out;

   int checks = 0;
   int errors = 0;
   int last_g = 1;

   sdr_arb #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
      .m0_wvld(wvld[0]), .m0_wready(wready[0]), .m0_rdata(m0_rdata),
      .m0_rvld(rvld[0]), .m0_ack(ack[0]), .m0_done(done[0]),
      .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
      .m1_wvld(wvld[1]), .m1_wready(wready[1]), .m1_rdata(m1_rdata),
      .m1_rvld(rvld[1]), .m1_ack(ack[1]), .m1_done(done[1]),
      .sdr_wr_req(sdr_wr_req), .sdr_waddr(sdr_waddr), .sdr_wdata_in(sdr_wdata_in),
      .sdr_wr_vld(sdr_wr_vld), .sdr_wr_ready(sdr_wr_ready),
      .sdr_rd_req(sdr_rd_req), .sdr_raddr(sdr_raddr), .sdr_rdata_out(sdr_rdata_out),
      .sdr_rd_vld(sdr_rd_vld), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd_vld;
      logic        wr_ready;
      logic [1:0]  wv;
      logic [15:0] rdata;
      logic [1:0]  exp_rvld;
      logic [1:0]  exp_wready;
      logic        exp_wr_vld;
   } idle_vec_t;

   idle_vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: a lone requester wins; a tie goes to the port not served last.
   function automatic int model_winner(input logic [1:0] r, input int last);
      if (r == 2'b11) return (last == 0) ? 1 : 0;
      return r[1] ? 1 : 0;
   endfunction

   // Entered in an IDLE cycle with req[g] driven; returns in the cycle done should pulse.
   task automatic run_burst(input int g, input bit stall);
      int o;
      int n;
      int cyc;
      o = 1 - g;
      n = 0;
      cyc = 0;
      #1;
      chk("idle_ack", 32'(ack), 0);
      chk("idle_sdr_req", {sdr_wr_req, sdr_rd_req}, 0);
      step;
      sdr_wr_ready = 1'($urandom);
      sdr_rd_vld   = 1'($urandom);
      wvld         = 2'($urandom);
      #1;
      chk("issue_ack", 32'(ack), 32'd1 << g);
      chk("issue_wr_req", sdr_wr_req, we[g]);
      chk("issue_rd_req", sdr_rd_req, !we[g]);
      chk("issue_addr", we[g] ? sdr_waddr : sdr_raddr, addr[g]);
      chk("issue_no_rvld", 32'(rvld), 0);
      chk("issue_no_wready", 32'(wready), 0);
      step;
      req[g] = 1'b0;
      while (n < BL && cyc < 300) begin
         sdr_rdata_out = 16'($urandom);
         wdata[0]      = 16'($urandom);
         wdata[1]      = 16'($urandom);
         wvld[o]       = 1'($urandom);
         if (we[g]) begin
            wvld[g]      = stall ? 1'($urandom) : 1'b1;
            sdr_wr_ready = stall ? 1'($urandom) : 1'b1;
            sdr_rd_vld   = 1'($urandom);
         end else begin
            wvld[g]      = 1'($urandom);
            sdr_wr_ready = 1'($urandom);
            sdr_rd_vld   = stall ? 1'($urandom) : 1'b1;
         end
         #1;
         chk("data_done", 32'(done), 0);
         chk("data_ack", 32'(ack), 0);
         chk("data_addr", we[g] ? sdr_waddr : sdr_raddr, addr[g]);
         chk("rdata0", 32'(m0_rdata), 32'(sdr_rdata_out));
         chk("rdata1", 32'(m1_rdata), 32'(sdr_rdata_out));
         if (we[g]) begin
            chk("wr_vld", sdr_wr_vld, wvld[g]);
            if (wvld[g]) chk("wdata", 32'(sdr_wdata_in), 32'(wdata[g]));
            chk("wready_g", wready[g], sdr_wr_ready);
            chk("wready_o", wready[o], 0);
            chk("rvld_in_wr", 32'(rvld), 0);
            if (wvld[g] && sdr_wr_ready) n++;
         end else begin
            chk("rvld_g", rvld[g], sdr_rd_vld);
            chk("rvld_o", rvld[o], 0);
            chk("wready_in_rd", 32'(wready), 0);
            chk("wr_vld_in_rd", sdr_wr_vld, 0);
            if (sdr_rd_vld) n++;
         end
         step;
         cyc++;
      end
      chk("beat_budget", n, BL);
      wvld = 2'b00;
      sdr_wr_ready = 1'b0;
      sdr_rd_vld = 1'b0;
      #1;
      chk("done", 32'(done), 32'd1 << g);
      chk("done_no_rvld", 32'(rvld), 0);
      chk("done_no_wr_vld", sdr_wr_vld, 0);
      last_g = g;
   endtask

   task automatic drain;
      while (req != 2'b00) run_burst(model_winner(req, last_g), 1'b1);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 2'b00, 16'hA5A5, 2'b00, 2'b00, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 2'b11, 16'h1234, 2'b00, 2'b00, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 2'b01, 16'hFFFF, 2'b00, 2'b00, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 2'b10, 16'h0000, 2'b00, 2'b00, 1'b0};

      req = '0; we = '0; wvld = '0;
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      sdr_wr_ready = 1'b0; sdr_rd_vld = 1'b0; sdr_rdata_out = '0;

      repeat (3) step;
      #1;
      chk("rst_ack", 32'(ack), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_sdr_req", {sdr_wr_req, sdr_rd_req}, 0);
      chk("rst_waddr", sdr_waddr, 0);
      chk("rst_raddr", sdr_raddr, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      step;

      // idle: stray controller strobes and beats must be ignored
      for (int i = 0; i < 4; i++) begin
         sdr_rd_vld = tbl[i].rd_vld;
         sdr_wr_ready = tbl[i].wr_ready;
         wvld = tbl[i].wv;
         sdr_rdata_out = tbl[i].rdata;
         #1;
         chk("idle_rvld", 32'(rvld), 32'(tbl[i].exp_rvld));
         chk("idle_wready", 32'(wready), 32'(tbl[i].exp_wready));
         chk("idle_wr_vld", sdr_wr_vld, tbl[i].exp_wr_vld);
         chk("idle_rdata0", 32'(m0_rdata), 32'(tbl[i].rdata));
         chk("idle_tbl_ack", 32'(ack), 0);
         step;
      end
      sdr_rd_vld = 1'b0; sdr_wr_ready = 1'b0; wvld = '0;

      // m0 write to 0x100
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h100;
      run_burst(0, 1'b0);

      // m1 read from 0x2000
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h2000;
      run_burst(1, 1'b0);

      // simultaneous requests, each port re-requesting after its done
      req = 2'b11; we[0] = 1'b1; we[1] = 1'b0;
      addr[0] = 32'h4000; addr[1] = 32'h8000;
      for (int i = 0; i < 4; i++) begin
         run_burst(i % 2, 1'b1);
         req[i % 2] = 1'b1;
      end
      drain;

      // randomized mix
      for (int i = 0; i < 24; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p] && $urandom_range(0, 1) == 1) begin
               req[p] = 1'b1; we[p] = 1'($urandom); addr[p] = $urandom;
            end
         end
         if (req == 2'b00) begin
            int p;
            p = int'($urandom_range(0, 1));
            req[p] = 1'b1; we[p] = 1'($urandom); addr[p] = $urandom;
         end
         run_burst(model_winner(req, last_g), 1'b1);
      end
      drain;

      // reset during write beat 3
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h300;
      #1;
      step;
      #1;
      chk("mid_ack", 32'(ack), 1);
      step;
      req[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wvld[0] = 1'b1; wdata[0] = 16'(16'h1000 + k); sdr_wr_ready = 1'b1;
         #1;
         chk("mid_pre_beat", sdr_wr_vld, 1);
         step;
      end
      #1;
      chk("mid_beat3_wready", wready[0], 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wready", 32'(wready), 0);
      chk("mid_rst_wr_vld", sdr_wr_vld, 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_waddr", sdr_waddr, 0);
      chk("mid_rst_err", err, 0);
      step;
      #1;
      chk("mid_rst_done2", 32'(done), 0);
      step;
      rst_n = 1'b1;
      #1;
      chk("post_rst_wr_vld", sdr_wr_vld, 0);
      chk("post_rst_wready", 32'(wready), 0);
      step;
      #1;
      chk("post_rst_done", 32'(done), 0);
      wvld = '0; sdr_wr_ready = 1'b0;
      last_g = 1;
      req = 2'b11; we[0] = 1'b0; we[1] = 1'b1;
      addr[0] = 32'h500; addr[1] = 32'h600;
      run_burst(0, 1'b1);
      drain;

      // stalled write
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h700;
      #1;
      step;
      #1;
      chk("stall_ack", 32'(ack), 1);
      step;
      req[0] = 1'b0;
`ifdef SDR_ARB_WDOG_EN
      for (int k = 0; k < int'(TO); k++) begin
         wvld[0] = 1'b1; sdr_wr_ready = 1'b0;
         #1;
         chk("wd_no_done", 32'(done), 0);
         chk("wd_in_wr", sdr_wr_vld, 1);
         chk("wd_err_low", err, 0);
         step;
      end
      #1;
      chk("wd_done", 32'(done), 1);
      chk("wd_err", err, 1);
      chk("wd_idle", sdr_wr_vld, 0);
      step;
      sdr_wr_ready = 1'b1;
      #1;
      chk("wd_done_once", 32'(done), 0);
      chk("wd_err_sticky", err, 1);
      chk("wd_idle_wready", 32'(wready), 0);
      wvld = '0; sdr_wr_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("wd_err_cleared", err, 0);
      step;
      rst_n = 1'b1;
      last_g = 1;
`else
      for (int k = 0; k < 40; k++) begin
         wvld[0] = 1'b1; sdr_wr_ready = 1'b0;
         #1;
         chk("stall_no_done", 32'(done), 0);
         chk("stall_in_wr", sdr_wr_vld, 1);
         chk("stall_wready", 32'(wready), 0);
         chk("stall_err", err, 0);
         step;
      end
      for (int k = 0; k < int'(BL); k++) begin
         sdr_wr_ready = 1'b1;
         #1;
         chk("stall_resume_done", 32'(done), 0);
         step;
      end
      wvld = '0; sdr_wr_ready = 1'b0;
      #1;
      chk("stall_done", 32'(done), 1);
      chk("stall_err_end", err, 0);
      last_g = 0;
`endif
      step;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
